// File: rtl/guvm_dcache_pkg.sv
// Shared types and helpers for the data-cache port responder.
package guvm_dcache_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        DRESP_IDLE = 2'd0,
        DRESP_WAIT = 2'd1,
        DRESP_RESP = 2'd2
    } dresp_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic              read;
        logic [1:0]        size;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dreq_t;

    // Bit 3 is the big-endian byte at offset 0 (bits [31:24]); reserved size acts as word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = 4'b1000 >> offset;
            SIZE_HALF: m = offset[1] ? 4'b0011 : 4'b1100;
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/guvm_byte_lane_merge.sv
// Merges right-justified store data into an existing word on big-endian byte lanes.
module guvm_byte_lane_merge
    import guvm_dcache_pkg::*;
(
    input  logic [DATA_W-1:0] old_word_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        offset_i,
    output logic [DATA_W-1:0] merged_c
);

    logic [3:0]        lanes_c;
    logic [DATA_W-1:0] repl_c;

    always_comb begin
        lanes_c = lane_mask(size_i, offset_i);
        case (size_i)
            SIZE_BYTE: repl_c = {4{wdata_i[7:0]}};
            SIZE_HALF: repl_c = {2{wdata_i[15:0]}};
            default:   repl_c = wdata_i;
        endcase
        merged_c = old_word_i;
        for (int i = 0; i < 4; i++) begin
            if (lanes_c[i]) begin
                merged_c[8*i +: 8] = repl_c[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/guvm_dcache_responder.sv
// Data-cache port responder: wait-stated load/store against a big-endian word memory.
// Optional DCACHE_RESP_ERRINJ_EN adds err_inj to force an illegal response.
module guvm_dcache_responder
    import guvm_dcache_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dci_enaddr,
    input  logic              dci_read,
    input  logic [1:0]        dci_size,
    input  logic [DATA_W-1:0] dci_addr,
    input  logic [DATA_W-1:0] dci_wdata,
`ifdef DCACHE_RESP_ERRINJ_EN
    input  logic              err_inj,
`endif
    output logic [DATA_W-1:0] dco_data,
    output logic              dco_hold,
    output logic              dco_mds,
    output logic              dco_mexc,
    output logic              dco_werr
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    dresp_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dreq_t             req_q, req_d, cur_req_c;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hold_q, hold_d;
    logic              mds_q, mds_d;
    logic              mexc_q, mexc_d;
    logic              werr_q, werr_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] off_c;
    logic [AW-1:0]     widx_c;
    logic [DATA_W-1:0] rdword_c;
    logic [DATA_W-1:0] merged_c;
    logic              misalign_c;
    logic              legal_c;
    logic              fire_c;
    logic              mem_we_c;
    logic              inj_c;

`ifdef DCACHE_RESP_ERRINJ_EN
    logic err_q;

    assign inj_c = (state_q == DRESP_IDLE) ? err_inj : err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state_q == DRESP_IDLE && dci_enaddr) begin
            err_q <= err_inj;
        end
    end
`else
    assign inj_c = 1'b0;
`endif

    // In IDLE the live request is decoded so a zero-wait response can fire directly.
    always_comb begin
        if (state_q == DRESP_IDLE) begin
            cur_req_c.read  = dci_read;
            cur_req_c.size  = dci_size;
            cur_req_c.addr  = dci_addr;
            cur_req_c.wdata = dci_wdata;
        end else begin
            cur_req_c = req_q;
        end
        off_c      = cur_req_c.addr - BASE_ADDR;
        widx_c     = off_c[AW+1:2];
        misalign_c = (cur_req_c.size == SIZE_HALF && off_c[0]) ||
                     (cur_req_c.size[1] && off_c[1:0] != 2'b00);
        legal_c    = (off_c[31:2] < 30'(DEPTH)) && !misalign_c && !inj_c;
        rdword_c   = mem[widx_c];
    end

    guvm_byte_lane_merge u_merge (
        .old_word_i (rdword_c),
        .wdata_i    (cur_req_c.wdata),
        .size_i     (cur_req_c.size),
        .offset_i   (off_c[1:0]),
        .merged_c   (merged_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        data_d  = data_q;
        hold_d  = 1'b1;
        mds_d   = 1'b0;
        mexc_d  = 1'b0;
        werr_d  = 1'b0;
        fire_c  = 1'b0;

        case (state_q)
            DRESP_IDLE: begin
                if (dci_enaddr) begin
                    req_d = cur_req_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DRESP_RESP;
                        fire_c  = 1'b1;
                    end else begin
                        state_d = DRESP_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        hold_d  = 1'b0;
                    end
                end
            end
            DRESP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DRESP_RESP;
                    fire_c  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    hold_d = 1'b0;
                end
            end
            DRESP_RESP: state_d = DRESP_IDLE;
            default:    state_d = DRESP_IDLE;
        endcase

        if (fire_c) begin
            if (cur_req_c.read) begin
                if (legal_c) begin
                    data_d = rdword_c;
                    mds_d  = 1'b1;
                end else begin
                    data_d = '0;
                    mexc_d = 1'b1;
                end
            end else begin
                werr_d = !legal_c;
            end
        end
        mem_we_c = fire_c && !cur_req_c.read && legal_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DRESP_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            data_q  <= '0;
            hold_q  <= 1'b1;
            mds_q   <= 1'b0;
            mexc_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            mds_q   <= mds_d;
            mexc_q  <= mexc_d;
            werr_q  <= werr_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[widx_c] <= merged_c;
        end
    end

    assign dco_data = data_q;
    assign dco_hold = hold_q;
    assign dco_mds  = mds_q;
    assign dco_mexc = mexc_q;
    assign dco_werr = werr_q;

endmodule

// File: tb/tb_guvm_dcache_responder.sv
// Scoreboard bench: one responder with 2 wait states at base 0, one with 0 wait states at 0x1000_0000.
`timescale 1ns/1ps
module tb_guvm_dcache_responder;
    import guvm_dcache_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE1 = 32'h1000_0000;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  kind;   // {mds, mexc, werr}
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en [2];
    logic        rd [2];
    logic [1:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] data [2];
    logic        hold [2];
    logic        mds [2];
    logic        mexc [2];
    logic        werr [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl0[int];
    logic [31:0] mdl1[int];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    guvm_dcache_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .dci_enaddr(en[0]), .dci_read(rd[0]), .dci_size(sz[0]),
        .dci_addr(ad[0]), .dci_wdata(wd[0]),
`ifdef DCACHE_RESP_ERRINJ_EN
        .err_inj(1'b0),
`endif
        .dco_data(data[0]), .dco_hold(hold[0]), .dco_mds(mds[0]),
        .dco_mexc(mexc[0]), .dco_werr(werr[0])
    );

    guvm_dcache_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE1)) u_dut0 (
        .clk(clk), .rst(rst),
        .dci_enaddr(en[1]), .dci_read(rd[1]), .dci_size(sz[1]),
        .dci_addr(ad[1]), .dci_wdata(wd[1]),
`ifdef DCACHE_RESP_ERRINJ_EN
        .err_inj(1'b0),
`endif
        .dco_data(data[1]), .dco_hold(hold[1]), .dco_mds(mds[1]),
        .dco_mexc(mexc[1]), .dco_werr(werr[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_get(input int sel, input int idx);
        if (sel == 0) return mdl0.exists(idx) ? mdl0[idx] : 32'hxxxx_xxxx;
        return mdl1.exists(idx) ? mdl1[idx] : 32'hxxxx_xxxx;
    endfunction

    // Reference big-endian store: offset 0 is the most significant byte.
    function automatic logic [31:0] mdl_merge(input logic [31:0] old, input logic [1:0] s,
                                              input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] r;
        int          top;
        r   = old;
        top = 31 - 8 * int'(lo);
        case (s)
            2'b00:   r[top -: 8]  = d[7:0];
            2'b01:   r[top -: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    // Pops the oldest expected response whenever a pulse appears.
    task automatic mon(input int sel);
        exp_t       e;
        logic [2:0] k;
        k = {mds[sel], mexc[sel], werr[sel]};
        if (k == 3'b000) return;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            check_eq($sformatf("dut%0d_unexpected_pulse", sel), 32'(k), 32'h0);
            return;
        end
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        check_eq($sformatf("dut%0d_resp_cycle", sel), cyc, e.cyc);
        check_eq($sformatf("dut%0d_resp_kind", sel), 32'(k), 32'(e.kind));
        if (e.kind[2] || e.kind[1])
            check_eq($sformatf("dut%0d_data", sel), data[sel], e.data);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0);
            mon(1);
        end
    end

    // Issues one request from an IDLE negedge and returns at the next IDLE negedge.
    task automatic do_req(input int sel, input logic r, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] off;
        bit          ok;
        int          idx;
        int unsigned wait_n;
        int unsigned lowcnt;
        wait_n = (sel == 0) ? 2 : 0;
        off    = a - ((sel == 0) ? 32'h0 : BASE1);
        ok     = (off < 32'(4 * DEPTH)) && !(s == 2'b01 && a[0]) && !(s[1] && a[1:0] != 2'b00);
        idx    = int'(off >> 2);
        en[sel] = 1'b1; rd[sel] = r; sz[sel] = s; ad[sel] = a; wd[sel] = d;
        @(posedge clk);
        #1;
        en[sel] = 1'b0;
        e.cyc   = cyc + wait_n;
        e.data  = 32'h0;
        if (r) begin
            e.kind = ok ? 3'b100 : 3'b010;
            if (ok) e.data = mdl_get(sel, idx);
        end else begin
            e.kind = 3'b001;
            if (ok) begin
                if (sel == 0) mdl0[idx] = mdl_merge(mdl_get(0, idx), s, a[1:0], d);
                else          mdl1[idx] = mdl_merge(mdl_get(1, idx), s, a[1:0], d);
            end
        end
        if (r || !ok) begin
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        lowcnt = 0;
        for (int k = 0; k <= int'(wait_n); k++) begin
            @(negedge clk);
            if (hold[sel] == 1'b0) lowcnt++;
        end
        check_eq($sformatf("dut%0d_hold_low_cycles", sel), lowcnt, wait_n);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; rd[i] = 1'b0; sz[i] = SIZE_WORD; ad[i] = '0; wd[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("dut%0d_rst_data", i), data[i], 32'h0);
            check_eq($sformatf("dut%0d_rst_hold", i), 32'(hold[i]), 32'h1);
            check_eq($sformatf("dut%0d_rst_pulses", i), 32'({mds[i], mexc[i], werr[i]}), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Word store / load round trip with two wait states.
        do_req(0, 1'b0, SIZE_WORD, 32'h0, 32'hDEAD_BEEF);
        do_req(0, 1'b1, SIZE_WORD, 32'h0, 32'h0);

        // Sub-word stores on big-endian lanes.
        do_req(0, 1'b0, SIZE_WORD, 32'h4, 32'h1122_3344);
        do_req(0, 1'b0, SIZE_BYTE, 32'h5, 32'hFFFF_FFAA);
        do_req(0, 1'b1, SIZE_WORD, 32'h4, 32'h0);
        check_eq("byte_merge_literal", data[0], 32'h11AA_3344);
        do_req(0, 1'b0, SIZE_HALF, 32'h6, 32'h0000_BEEF);
        do_req(0, 1'b1, SIZE_HALF, 32'h6, 32'h0);
        do_req(0, 1'b1, SIZE_BYTE, 32'h7, 32'h0);

        // Misaligned accesses.
        do_req(0, 1'b1, SIZE_HALF, 32'h3, 32'h0);
        do_req(0, 1'b0, SIZE_WORD, 32'h2, 32'h5555_5555);
        do_req(0, 1'b1, 2'b11, 32'h1, 32'h0);
        do_req(0, 1'b1, SIZE_WORD, 32'h0, 32'h0);

        // Range boundary.
        do_req(0, 1'b0, SIZE_WORD, 32'hFFC, 32'h0BAD_F00D);
        do_req(0, 1'b1, SIZE_WORD, 32'h1000, 32'h0);
        do_req(0, 1'b0, SIZE_WORD, 32'h1000, 32'h1234_5678);
        do_req(0, 1'b1, SIZE_WORD, 32'hFFC, 32'h0);

        // Zero-wait instance with a non-zero base, back-to-back traffic.
        do_req(1, 1'b0, SIZE_WORD, BASE1, 32'hCAFE_F00D);
        do_req(1, 1'b0, SIZE_WORD, BASE1 + 32'h4, 32'h0102_0304);
        do_req(1, 1'b0, SIZE_BYTE, BASE1 + 32'h4, 32'h0000_00EE);
        do_req(1, 1'b1, SIZE_WORD, BASE1, 32'h0);
        do_req(1, 1'b1, SIZE_WORD, BASE1 + 32'h4, 32'h0);
        do_req(1, 1'b1, SIZE_HALF, BASE1 + 32'h2, 32'h0);
        do_req(1, 1'b1, SIZE_WORD, 32'h0, 32'h0);
        do_req(1, 1'b1, SIZE_WORD, BASE1 + 32'h1000, 32'h0);

        // Reset in the middle of a store's wait window discards it.
        en[0] = 1'b1; rd[0] = 1'b0; sz[0] = SIZE_WORD; ad[0] = 32'h0; wd[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_wait_hold_before", 32'(hold[0]), 32'h0);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_wait_hold_async", 32'(hold[0]), 32'h1);
        @(posedge clk);
        #1;
        check_eq("rst_mid_wait_hold_edge", 32'(hold[0]), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_req(0, 1'b1, SIZE_WORD, 32'h0, 32'h0);

        // Random mix over a preloaded window.
        for (int i = 0; i < 8; i++)
            do_req(0, 1'b0, SIZE_WORD, 32'h40 + 32'(4 * i), $urandom);
        for (int i = 0; i < 24; i++)
            do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   32'h40 + 32'($urandom_range(0, 31)), $urandom);

        repeat (4) @(negedge clk);
        check_eq("dut0_queue_drained", 32'(q0.size()), 32'h0);
        check_eq("dut1_queue_drained", 32'(q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
